// File: rtl/fab_pkg.sv
// Shared types and constants for the fetch align buffer.
// Imported by the word buffer and the top module.
package fab_pkg;

    localparam int unsigned TAG_W = 30;

    localparam logic [1:0] RVC_NOT = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } fab_state_e;

endpackage

// File: rtl/fab_word_buffer.sv
// Two tagged instruction words with LRU replacement.
// Looks up two tags at once and takes one fill per cycle.
module fab_word_buffer
    import fab_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [TAG_W-1:0] tag_a_i,
    input  logic [TAG_W-1:0] tag_b_i,
    input  logic             use_b_i,
    output logic             hit_a_o,
    output logic [31:0]      data_a_o,
    output logic             hit_b_o,
    output logic [31:0]      data_b_o,
    input  logic             fill_en_i,
    input  logic [TAG_W-1:0] fill_tag_i,
    input  logic [31:0]      fill_data_i
);

    logic [1:0]       vld_q;
    logic [TAG_W-1:0] tag_q [2];
    logic [31:0]      data_q [2];
    logic             lru_q;
    logic             lru_d;

    logic [1:0] match_a;
    logic [1:0] match_b;
    logic [1:0] keep;
    logic       victim;

    // Dual tag compare; tags are unique so at most one entry matches each.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            match_a[i] = vld_q[i] && (tag_q[i] == tag_a_i);
            match_b[i] = vld_q[i] && (tag_q[i] == tag_b_i);
        end
        keep     = match_a | match_b;
        hit_a_o  = |match_a;
        hit_b_o  = |match_b;
        data_a_o = match_a[1] ? data_q[1] : data_q[0];
        data_b_o = match_b[1] ? data_q[1] : data_q[0];
    end

    // Victim: prefer an entry not holding W or W+1, else fall back to LRU.
    always_comb begin
        victim = lru_q;
        if (keep[0] && !keep[1]) begin
            victim = 1'b1;
        end else if (!keep[0] && keep[1]) begin
            victim = 1'b0;
        end
    end

    // LRU update: used hits mark MRU, a fill into the victim wins last.
    always_comb begin
        lru_d = lru_q;
        if (use_b_i && hit_b_o) begin
            lru_d = !match_b[1];
        end
        if (hit_a_o) begin
            lru_d = !match_a[1];
        end
        if (fill_en_i) begin
            lru_d = !victim;
        end
    end

    // Entry storage and replacement state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q     <= '0;
            tag_q[0]  <= '0;
            tag_q[1]  <= '0;
            data_q[0] <= '0;
            data_q[1] <= '0;
            lru_q     <= 1'b0;
        end else begin
            lru_q <= lru_d;
            if (fill_en_i) begin
                vld_q[victim]  <= 1'b1;
                tag_q[victim]  <= fill_tag_i;
                data_q[victim] <= fill_data_i;
            end
        end
    end

endmodule

// File: rtl/fetch_align_buffer.sv
// Fetch align buffer: presents the aligned 16/32-bit instruction at pc
// and owns the ICACHE read port, prefetching the next sequential word.
module fetch_align_buffer
    import fab_pkg::*;
#(
    parameter bit PREFETCH_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      pc,
    output logic             ready,
    output logic             compressed,
    output logic [31:0]      inst,
    input  logic             ICACHE_stall,
    output logic             ICACHE_ren,
    output logic             ICACHE_wen,
    output logic [TAG_W-1:0] ICACHE_addr,
    input  logic [31:0]      ICACHE_rdata,
    output logic [31:0]      ICACHE_wdata
);

    fab_state_e       state_q;
    logic             ren_q;
    logic [TAG_W-1:0] addr_q;

    logic [TAG_W-1:0] w;
    logic [TAG_W-1:0] w1;
    logic             hit_a;
    logic             hit_b;
    logic [31:0]      data_a;
    logic [31:0]      data_b;
    logic [15:0]      half;
    logic             is32;
    logic             need_b;
    logic             fill_en;
    logic             tgt_vld;
    logic [TAG_W-1:0] tgt_d;

    logic             pc_unused;
    logic [15:0]      data_b_hi_unused;

    assign pc_unused        = pc[0];
    assign data_b_hi_unused = data_b[31:16];

    assign w  = pc[31:2];
    assign w1 = w + 30'd1;

    assign fill_en = (state_q == REQ) && !ICACHE_stall;

    fab_word_buffer u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .tag_a_i     (w),
        .tag_b_i     (w1),
        .use_b_i     (need_b),
        .hit_a_o     (hit_a),
        .data_a_o    (data_a),
        .hit_b_o     (hit_b),
        .data_b_o    (data_b),
        .fill_en_i   (fill_en),
        .fill_tag_i  (addr_q),
        .fill_data_i (ICACHE_rdata)
    );

    // Alignment: pick the halfword at pc and splice across words if needed.
    always_comb begin
        half       = pc[1] ? data_a[31:16] : data_a[15:0];
        is32       = (half[1:0] == RVC_NOT);
        need_b     = pc[1] && is32;
        ready      = hit_a && (!need_b || hit_b);
        compressed = ready && !is32;
        inst       = '0;
        if (ready) begin
            if (!is32) begin
                inst = {16'h0000, half};
            end else if (pc[1]) begin
                inst = {data_b[15:0], data_a[31:16]};
            end else begin
                inst = data_a;
            end
        end
    end

    // Next fetch target: current word, then spill word, then prefetch.
    always_comb begin
        tgt_vld = 1'b0;
        tgt_d   = w;
        if (!hit_a) begin
            tgt_vld = 1'b1;
            tgt_d   = w;
        end else if (need_b && !hit_b) begin
            tgt_vld = 1'b1;
            tgt_d   = w1;
        end else if (PREFETCH_EN && !hit_b) begin
            tgt_vld = 1'b1;
            tgt_d   = w1;
        end
    end

    // Request FSM; the port is driven only from these registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ren_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (tgt_vld) begin
                        addr_q  <= tgt_d;
                        ren_q   <= 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (!ICACHE_stall) begin
                        ren_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign ICACHE_ren   = ren_q;
    assign ICACHE_addr  = addr_q;
    assign ICACHE_wen   = 1'b0;
    assign ICACHE_wdata = '0;

endmodule

// File: tb/tb_fetch_align_buffer.sv
// Directed bench for fetch_align_buffer with a small ICACHE memory model.
// Each step sets inputs just after a rising edge and checks mid-cycle.
module tb_fetch_align_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic        ready;
    logic        compressed;
    logic [31:0] inst;
    logic        ICACHE_stall;
    logic        ICACHE_ren;
    logic        ICACHE_wen;
    logic [29:0] ICACHE_addr;
    logic [31:0] ICACHE_rdata;
    logic [31:0] ICACHE_wdata;

    logic [31:0] mem [256];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign ICACHE_rdata = mem[ICACHE_addr[7:0]];

    fetch_align_buffer #(.PREFETCH_EN(1'b1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc           (pc),
        .ready        (ready),
        .compressed   (compressed),
        .inst         (inst),
        .ICACHE_stall (ICACHE_stall),
        .ICACHE_ren   (ICACHE_ren),
        .ICACHE_wen   (ICACHE_wen),
        .ICACHE_addr  (ICACHE_addr),
        .ICACHE_rdata (ICACHE_rdata),
        .ICACHE_wdata (ICACHE_wdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        ICACHE_stall = 1'b0;
        cyc();
        cyc();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;
        rst_n        = 1'b0;
        pc           = 32'h0;
        ICACHE_stall = 1'b0;

        // A: reset values, then single-word miss and prefetch
        mem[0] = 32'h0000_0013;
        mem[1] = 32'h0010_0093;
        do_reset();
        #2;
        chk("rst_ready", ready, 1'b0);
        chk("rst_comp", compressed, 1'b0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_ren", ICACHE_ren, 1'b0);
        chk("rst_addr", ICACHE_addr, 30'h0);
        chk("rst_wen", ICACHE_wen, 1'b0);
        chk("rst_wdata", ICACHE_wdata, 32'h0);
        rst_n = 1'b1;
        pc    = 32'h0;
        #2;
        chk("A0_ready", ready, 1'b0);
        chk("A0_ren", ICACHE_ren, 1'b0);
        cyc(); #2;
        chk("A1_ren", ICACHE_ren, 1'b1);
        chk("A1_addr", ICACHE_addr, 30'h0);
        chk("A1_ready", ready, 1'b0);
        cyc(); #2;
        chk("A2_ready", ready, 1'b1);
        chk("A2_inst", inst, 32'h0000_0013);
        chk("A2_comp", compressed, 1'b0);
        chk("A2_ren", ICACHE_ren, 1'b0);
        cyc(); #2;
        chk("A3_ren", ICACHE_ren, 1'b1);
        chk("A3_addr", ICACHE_addr, 30'h1);

        // B: compressed upper half, then zero-latency hits
        mem[0] = 32'h4501_0001;
        mem[1] = 32'h0010_0093;
        do_reset();
        rst_n = 1'b1;
        pc    = 32'h2;
        cyc();
        cyc(); #2;
        chk("B2_ready", ready, 1'b1);
        chk("B2_comp", compressed, 1'b1);
        chk("B2_inst", inst, 32'h0000_4501);
        cyc();
        cyc(); #2;
        chk("B4_ready", ready, 1'b1);
        chk("B4_inst", inst, 32'h0000_4501);
        cyc();
        pc = 32'h4;
        #2;
        chk("B5_ready", ready, 1'b1);
        chk("B5_comp", compressed, 1'b0);
        chk("B5_inst", inst, 32'h0010_0093);

        // C: spanning 32-bit instruction, both words absent
        mem[1] = 32'h0513_4501;
        mem[2] = 32'h0000_0000;
        do_reset();
        rst_n = 1'b1;
        pc    = 32'h6;
        #2;
        chk("C0_ready", ready, 1'b0);
        cyc(); #2;
        chk("C1_ren", ICACHE_ren, 1'b1);
        chk("C1_addr", ICACHE_addr, 30'h1);
        cyc(); #2;
        chk("C2_ready", ready, 1'b0);
        chk("C2_ren", ICACHE_ren, 1'b0);
        cyc(); #2;
        chk("C3_ren", ICACHE_ren, 1'b1);
        chk("C3_addr", ICACHE_addr, 30'h2);
        chk("C3_ready", ready, 1'b0);
        cyc(); #2;
        chk("C4_ready", ready, 1'b1);
        chk("C4_comp", compressed, 1'b0);
        chk("C4_inst", inst, 32'h0000_0513);

        // G: spanning across the top of the address space
        mem[255] = 32'h0793_0001;
        mem[0]   = 32'h0000_1234;
        do_reset();
        rst_n = 1'b1;
        pc    = 32'hFFFF_FFFE;
        cyc(); #2;
        chk("G1_addr", ICACHE_addr, 30'h3FFF_FFFF);
        cyc();
        cyc(); #2;
        chk("G3_ren", ICACHE_ren, 1'b1);
        chk("G3_addr", ICACHE_addr, 30'h0);
        cyc(); #2;
        chk("G4_ready", ready, 1'b1);
        chk("G4_inst", inst, 32'h1234_0793);

        // D: miss held off by five stall cycles
        mem[16] = 32'h0050_0113;
        do_reset();
        rst_n        = 1'b1;
        pc           = 32'h40;
        ICACHE_stall = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            cyc();
            if (c == 6) ICACHE_stall = 1'b0;
            #2;
            chk("D_ren", ICACHE_ren, 1'b1);
            chk("D_addr", ICACHE_addr, 30'h10);
            chk("D_ready", ready, 1'b0);
        end
        cyc(); #2;
        chk("D7_ready", ready, 1'b1);
        chk("D7_inst", inst, 32'h0050_0113);

        // E: redirect during prefetch; LRU victim keeps word 0x40
        mem[8'h40] = 32'h0000_0093;
        mem[8'h41] = 32'h0000_0113;
        mem[8'h80] = 32'h0000_0193;
        do_reset();
        rst_n = 1'b1;
        pc    = 32'h100;
        cyc();
        cyc();
        ICACHE_stall = 1'b1;
        #2;
        chk("E2_ready", ready, 1'b1);
        chk("E2_inst", inst, 32'h0000_0093);
        cyc(); #2;
        chk("E3_ren", ICACHE_ren, 1'b1);
        chk("E3_addr", ICACHE_addr, 30'h41);
        cyc();
        pc = 32'h200;
        #2;
        chk("E4_ready", ready, 1'b0);
        chk("E4_addr", ICACHE_addr, 30'h41);
        cyc();
        ICACHE_stall = 1'b0;
        cyc();
        ICACHE_stall = 1'b1;
        #2;
        chk("E6_ren", ICACHE_ren, 1'b0);
        cyc();
        pc = 32'h100;
        #2;
        chk("E7_ren", ICACHE_ren, 1'b1);
        chk("E7_addr", ICACHE_addr, 30'h80);
        chk("E7_ready", ready, 1'b1);
        chk("E7_inst", inst, 32'h0000_0093);
        cyc();
        pc = 32'h104;
        #2;
        chk("E8_ready", ready, 1'b1);
        chk("E8_inst", inst, 32'h0000_0113);

        // F: reset while a request is outstanding
        do_reset();
        rst_n = 1'b1;
        pc    = 32'h0;
        cyc();
        cyc();
        ICACHE_stall = 1'b1;
        #2;
        chk("F2_ready", ready, 1'b1);
        cyc(); #2;
        chk("F3_ren", ICACHE_ren, 1'b1);
        chk("F3_addr", ICACHE_addr, 30'h1);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        #2;
        chk("F4_ren", ICACHE_ren, 1'b0);
        chk("F4_ready", ready, 1'b0);
        cyc(); #2;
        chk("F5_ren", ICACHE_ren, 1'b1);
        chk("F5_addr", ICACHE_addr, 30'h0);
        chk("F5_ready", ready, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
